// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the multiplexed BCD display scanner.
// Holds the state encoding, digit constants and the leading-zero blanking rule.
package bcd_disp_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  // Digit idx is blanked when it and every higher digit are zero; digit 0 always shows.
  function automatic logic lz_mask_bit(input logic [31:0] word, input logic lzb, input int idx);
    return lzb && (idx != 0) && ((word >> (DIGIT_W * idx)) == 32'd0);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// A phase of N cycles is timed by loading N-1 on entry and leaving on tc.
module scan_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Time-multiplexed digit scanner feeding one shared BCD-to-7-segment decoder.
// Double-buffered display word; guard gap with all digits off before each slot.
module bcd_scan_ctrl
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int GUARD_CYCLES = 500,
  parameter int SHOW_CYCLES  = 12000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          lzb,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_data,
  output logic [DIGIT_W-1:0]            bcd_out,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic                          frame_done,
  output logic                          invalid_digit
);

  localparam int MAX_CYC = (GUARD_CYCLES > SHOW_CYCLES) ? GUARD_CYCLES : SHOW_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int WORD_W  = DIGIT_W * NUM_DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  scan_state_e             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [WORD_W-1:0]       active_q, active_d, shadow_q, shadow_d;
  logic                    pending_q, pending_d;
  logic [DIGIT_W-1:0]      bcd_out_q, bcd_out_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    frame_done_q, frame_done_d;
  logic                    invalid_q, invalid_d;

  logic                    tmr_load, tmr_tc;
  logic [CNT_W-1:0]        tmr_val;
  logic                    boundary, enter_guard, enter_show;
  logic [DIGIT_W-1:0]      cur_digit;
  logic                    cur_invalid, cur_blank;

  scan_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    bcd_out_d    = bcd_out_q;
    digit_en_d   = digit_en_q;
    invalid_d    = invalid_q;
    frame_done_d = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    boundary     = 1'b0;
    enter_guard  = 1'b0;
    enter_show   = 1'b0;

    if (!enable) begin
      state_d  = ST_IDLE;
      idx_d    = '0;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_GUARD;
          idx_d       = '0;
          tmr_load    = 1'b1;
          tmr_val     = CNT_W'(GUARD_CYCLES - 1);
          boundary    = 1'b1;
          enter_guard = 1'b1;
        end
        ST_GUARD: if (tmr_tc) begin
          state_d    = ST_SHOW;
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(SHOW_CYCLES - 1);
          enter_show = 1'b1;
        end
        ST_SHOW: if (tmr_tc) begin
          state_d     = ST_GUARD;
          tmr_load    = 1'b1;
          tmr_val     = CNT_W'(GUARD_CYCLES - 1);
          enter_guard = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d        = '0;
            boundary     = 1'b1;
            frame_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A load coinciding with the frame boundary bypasses the shadow.
    if (boundary && load) begin
      active_d  = load_data;
      pending_d = 1'b0;
    end else if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d = load_data;
      if (!boundary) pending_d = 1'b1;
    end

    cur_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx_d == IDX_W'(i)) cur_digit = active_d[DIGIT_W*i +: DIGIT_W];
    cur_invalid = (cur_digit > BCD_MAX);
    cur_blank   = cur_invalid || lz_mask_bit(32'(active_d), lzb, int'(idx_d));

    // Outputs only move on slot/phase edges, so they stay glitch-free mid-slot.
    if (!enable) begin
      bcd_out_d  = '0;
      digit_en_d = '0;
      invalid_d  = 1'b0;
    end else if (enter_guard) begin
      bcd_out_d  = cur_digit;
      invalid_d  = cur_invalid;
      digit_en_d = '0;
    end else if (enter_show) begin
      digit_en_d = cur_blank ? '0 : (NUM_DIGITS'(1) << idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      bcd_out_q    <= '0;
      digit_en_q   <= '0;
      frame_done_q <= 1'b0;
      invalid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      bcd_out_q    <= bcd_out_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
      invalid_q    <= invalid_d;
    end
  end

  assign bcd_out       = bcd_out_q;
  assign digit_en      = digit_en_q;
  assign frame_done    = frame_done_q;
  assign invalid_digit = invalid_q;

endmodule
